bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_pkg.sv | 17 +
 rtl/bin2bcd_seq_if.sv | 21 ++
 rtl/bin2bcd_seq_bcd_digit_adj.sv | 13 +
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 tb/tb_bin2bcd_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One double-dabble iteration per binary input bit.
  localparam int          ITER    = 32;
  // Largest value representable in eight BCD digits.
  localparam logic [31:0] MAX_DEC = 32'd99_999_999;
  // Saturated result reported for operands above MAX_DEC.
  localparam logic [31:0] SAT_BCD = 32'h9999_9999;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a requester (master) and the converter (slave).
interface bin2bcd_seq_if;
  import bin2bcd_seq_pkg::*;

  logic        i_start;
  logic [31:0] i_bin;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_bcd;
  logic        o_ovf;

  modport master (
    output i_start, i_bin,
    input  o_busy, o_valid, o_bcd, o_ovf
  );

  modport slave (
    input  i_start, i_bin,
    output o_busy, o_valid, o_bcd, o_ovf
  );
endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  // Pre-shift correction so the following left shift carries into the next digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit BCD converter with saturation.
// Fixed latency: accept edge, 32 shift edges, then a one-cycle DONE.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
(
  input logic             clk,
  input logic             rst,
  bin2bcd_seq_if.slave    bus
);

  state_t      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [31:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  logic [31:0] acc_adj;
  logic [31:0] acc_shift;
  logic        last_iter;

  // Per-digit +3 correction on the accumulator as it stands before the shift.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i (acc_q[gi*4 +: 4]),
        .digit_o (acc_adj[gi*4 +: 4])
      );
    end
  endgenerate

  // Carry out of the top digit is dropped; it only happens on saturating operands.
  assign acc_shift = {acc_adj[30:0], shreg_q[31]};
  assign last_iter = (cnt_q == 6'(ITER - 1));

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d    = ST_SHIFT;
          shreg_d    = bus.i_bin;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (bus.i_bin > MAX_DEC);
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[30:0], 1'b0};
        acc_d   = acc_shift;
        cnt_d   = cnt_q + 6'd1;
        if (last_iter) begin
          state_d = ST_DONE;
          bcd_d   = ovf_pend_q ? SAT_BCD : acc_shift;
          ovf_d   = ovf_pend_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any running conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o_bcd   = bcd_q;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, corner sequences, random operands.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bin2bcd_seq_if bif ();

  bin2bcd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;

  typedef struct {
    logic [31:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [0:10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (bif.o_valid === 1'b1) valid_cnt++;
  endtask

  // Reference: decimal digits by plain division, saturating above 99,999,999.
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    x = longint'(v);
    if (x > 64'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion: start, wait for o_valid with a bound, then step past DONE.
  task automatic run_conv(input logic [31:0] bin, output logic [31:0] bcd,
                          output logic ovf, output int lat);
    logic [31:0] held;
    logic        held_ok;
    int          v0;
    held    = bif.o_bcd;
    held_ok = 1'b1;
    v0      = valid_cnt;
    bif.i_bin   = bin;
    bif.i_start = 1'b1;
    step();
    bif.i_start = 1'b0;
    bif.i_bin   = $urandom;
    check("busy_after_accept", 32'(bif.o_busy), 32'd1);
    lat = 0;
    while (bif.o_valid !== 1'b1 && lat < 100) begin
      if (bif.o_bcd !== held) held_ok = 1'b0;
      step();
      lat++;
    end
    bcd = bif.o_bcd;
    ovf = bif.o_ovf;
    check("bcd_held_during_conv", 32'(held_ok), 32'd1);
    step();
    check("valid_one_cycle", 32'(bif.o_valid), 32'd0);
    check("idle_after_done", 32'(bif.o_busy), 32'd0);
    check("valid_count", 32'(valid_cnt - v0), 32'd1);
  endtask

  initial begin
    logic [31:0] bcd, rb;
    logic        ovf;
    int          lat, v0;

    vecs[0]  = '{32'd12_345_678, 32'h1234_5678, 1'b0};
    vecs[1]  = '{32'd0,          32'h0000_0000, 1'b0};
    vecs[2]  = '{32'd99_999_999, 32'h9999_9999, 1'b0};
    vecs[3]  = '{32'd100_000_000,32'h9999_9999, 1'b1};
    vecs[4]  = '{32'hFFFF_FFFF,  32'h9999_9999, 1'b1};
    vecs[5]  = '{32'd1,          32'h0000_0001, 1'b0};
    vecs[6]  = '{32'd9,          32'h0000_0009, 1'b0};
    vecs[7]  = '{32'd10,         32'h0000_0010, 1'b0};
    vecs[8]  = '{32'd99_999_998, 32'h9999_9998, 1'b0};
    vecs[9]  = '{32'd50_000_005, 32'h5000_0005, 1'b0};
    vecs[10] = '{32'd0,          32'h0000_0000, 1'b0};

    bif.i_start = 1'b0;
    bif.i_bin   = '0;
    step();
    step();
    check("rst_busy",  32'(bif.o_busy),  32'd0);
    check("rst_valid", 32'(bif.o_valid), 32'd0);
    check("rst_bcd",   bif.o_bcd,        32'h0);
    check("rst_ovf",   32'(bif.o_ovf),   32'd0);
    rst = 1'b0;

    // Table vectors, back to back (34-cycle spacing, first one right after reset release).
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, bcd, ovf, lat);
      check($sformatf("vec%0d_bcd", i), bcd, vecs[i].bcd);
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd32);
      $display("vec %0d: bin=%0d bcd=%h ovf=%0d lat=%0d", i, vecs[i].bin, bcd, ovf, lat);
    end

    // Start re-pulsed at edges 5 and 33 with other operands: both ignored.
    v0 = valid_cnt;
    bif.i_bin = 32'd24_681_357;
    bif.i_start = 1'b1;
    step();                                  // edge 0
    bif.i_start = 1'b0;
    repeat (4) step();                       // edges 1..4
    bif.i_bin = 32'd777;
    bif.i_start = 1'b1;
    step();                                  // edge 5
    bif.i_start = 1'b0;
    repeat (27) step();                      // edges 6..32
    check("ign_valid_at_32", 32'(bif.o_valid), 32'd1);
    check("ign_bcd", bif.o_bcd, 32'h2468_1357);
    bif.i_bin = 32'd555;
    bif.i_start = 1'b1;
    step();                                  // edge 33
    bif.i_start = 1'b0;
    check("ign_busy_after_33", 32'(bif.o_busy), 32'd0);
    repeat (3) step();
    check("ign_busy_later", 32'(bif.o_busy), 32'd0);
    check("ign_single_valid", 32'(valid_cnt - v0), 32'd1);
    check("ign_bcd_kept", bif.o_bcd, 32'h2468_1357);
    $display("ignore seq: bcd=%h valids=%0d", bif.o_bcd, valid_cnt - v0);

    // Reset at edge 15 aborts the conversion.
    v0 = valid_cnt;
    bif.i_bin = 32'd11_111_111;
    bif.i_start = 1'b1;
    step();                                  // edge 0
    bif.i_start = 1'b0;
    repeat (14) step();                      // edges 1..14
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(bif.o_busy),  32'd0);
    check("abort_valid", 32'(bif.o_valid), 32'd0);
    check("abort_bcd",   bif.o_bcd,        32'h0);
    check("abort_ovf",   32'(bif.o_ovf),   32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (30) step();
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("abort_bcd_after", bif.o_bcd, 32'h0);
    run_conv(32'd87_654_321, bcd, ovf, lat);
    check("post_abort_bcd", bcd, 32'h8765_4321);
    check("post_abort_lat", 32'(lat), 32'd32);
    $display("reset seq: post-abort bcd=%h lat=%0d", bcd, lat);

    // Random operands against the decimal reference model.
    for (int k = 0; k < 200; k++) begin
      logic [31:0] b;
      if (k % 10 == 9) b = $urandom;
      else             b = 32'($urandom_range(99_999_999, 0));
      run_conv(b, bcd, ovf, lat);
      rb = ref_bcd(b);
      check("rand_bcd", bcd, rb);
      check("rand_ovf", 32'(ovf), 32'(b > 32'd99_999_999));
      check("rand_lat", 32'(lat), 32'd32);
      $display("rand %0d: bin=%0d bcd=%h ref=%h ovf=%0d", k, b, bcd, rb, ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
